// File: rtl/path_metric_sequencer.sv
// rtl/path_metric_sequencer.sv - frame sequencer feeding a path-metric unit and starting traceback
module path_metric_sequencer #(
  parameter int unsigned FRAME_LEN = 16,
  parameter logic [7:0]  INIT_BIAS = 8'd63
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       code_valid_i,
  output logic       code_ready_o,
  input  logic [1:0] code_in_i,
  output logic       pm_st_o,
  output logic [1:0] pm_code_o,
  output logic [7:0] pm_cur0_o,
  output logic [7:0] pm_cur1_o,
  output logic [7:0] pm_cur2_o,
  output logic [7:0] pm_cur3_o,
  input  logic [7:0] pm_new0_i,
  input  logic [7:0] pm_new1_i,
  input  logic [7:0] pm_new2_i,
  input  logic [7:0] pm_new3_i,
  input  logic       pm_done_i,
  output logic [7:0] step_cnt_o,
  output logic       tb_start_o,
  output logic [1:0] best_state_o,
  input  logic       tb_done_i,
  output logic       frame_done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_TB    = 2'd2,
    S_REARM = 2'd3
  } state_e;

  localparam logic [7:0] FRAME_LEN_W = 8'(FRAME_LEN);

  state_e          state_q, state_d;
  logic [1:0]      pm_code_q, pm_code_d;
  logic [3:0][7:0] cur_q, cur_d;
  logic [7:0]      step_q, step_d;
  logic [1:0]      best_q, best_d;
  logic            tb_first_q, tb_first_d;

  logic [3:0][7:0] new_w;
  logic [7:0]      min01, min23, min_all;
  logic [7:0]      step_inc;
  logic [1:0]      best_new;

  assign new_w = {pm_new3_i, pm_new2_i, pm_new1_i, pm_new0_i};

  // Normalising by the minimum keeps the winning state at zero, so the
  // traceback start is simply the first zero metric.
  assign min01   = (new_w[1] < new_w[0]) ? new_w[1] : new_w[0];
  assign min23   = (new_w[3] < new_w[2]) ? new_w[3] : new_w[2];
  assign min_all = (min23 < min01) ? min23 : min01;
  assign step_inc = step_q + 8'd1;

  always_comb begin
    best_new = 2'd3;
    if (new_w[0] == min_all)      best_new = 2'd0;
    else if (new_w[1] == min_all) best_new = 2'd1;
    else if (new_w[2] == min_all) best_new = 2'd2;
  end

  always_comb begin
    state_d    = state_q;
    pm_code_d  = pm_code_q;
    cur_d      = cur_q;
    step_d     = step_q;
    best_d     = best_q;
    tb_first_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (code_valid_i) begin
          pm_code_d = code_in_i;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (pm_done_i) begin
          for (int i = 0; i < 4; i++) begin
            cur_d[i] = new_w[i] - min_all;
          end
          step_d = step_inc;
          if (step_inc < FRAME_LEN_W) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_TB;
            tb_first_d = 1'b1;
            best_d     = best_new;
          end
        end
      end
      S_TB: begin
        if (tb_done_i) begin
          state_d = S_REARM;
        end
      end
      S_REARM: begin
        cur_d   = {INIT_BIAS, INIT_BIAS, INIT_BIAS, 8'd0};
        step_d  = 8'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pm_code_q  <= 2'd0;
      cur_q      <= {INIT_BIAS, INIT_BIAS, INIT_BIAS, 8'd0};
      step_q     <= 8'd0;
      best_q     <= 2'd0;
      tb_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pm_code_q  <= pm_code_d;
      cur_q      <= cur_d;
      step_q     <= step_d;
      best_q     <= best_d;
      tb_first_q <= tb_first_d;
    end
  end

  assign code_ready_o = (state_q == S_IDLE);
  assign pm_st_o      = (state_q == S_RUN);
  assign pm_code_o    = pm_code_q;
  assign pm_cur0_o    = cur_q[0];
  assign pm_cur1_o    = cur_q[1];
  assign pm_cur2_o    = cur_q[2];
  assign pm_cur3_o    = cur_q[3];
  assign step_cnt_o   = step_q;
  assign best_state_o = best_q;
  // The flag is only ever set on the RUN->TB edge, so it marks the first TB cycle.
  assign tb_start_o   = tb_first_q && (state_q == S_TB);
  assign frame_done_o = tb_first_q && (state_q == S_TB);

endmodule

// File: tb/tb_path_metric_sequencer.sv
// tb/tb_path_metric_sequencer.sv - randomized self-checking bench for path_metric_sequencer
module tb_path_metric_sequencer;

  localparam int FL = 4;
  localparam int BIAS = 63;

  logic       clk, rst_n, code_valid, code_ready, pm_st, pm_done, tb_start, tb_done, frame_done;
  logic [1:0] code_in, pm_code, best_state;
  logic [7:0] pm_cur0, pm_cur1, pm_cur2, pm_cur3, pm_new0, pm_new1, pm_new2, pm_new3, step_cnt;

  int total, bad;
  int m_cur[4];
  int m_step;
  int m_best;

  path_metric_sequencer #(.FRAME_LEN(FL), .INIT_BIAS(8'd63)) dut (
    .clk_i(clk), .rst_ni(rst_n), .code_valid_i(code_valid), .code_ready_o(code_ready),
    .code_in_i(code_in), .pm_st_o(pm_st), .pm_code_o(pm_code),
    .pm_cur0_o(pm_cur0), .pm_cur1_o(pm_cur1), .pm_cur2_o(pm_cur2), .pm_cur3_o(pm_cur3),
    .pm_new0_i(pm_new0), .pm_new1_i(pm_new1), .pm_new2_i(pm_new2), .pm_new3_i(pm_new3),
    .pm_done_i(pm_done), .step_cnt_o(step_cnt), .tb_start_o(tb_start),
    .best_state_o(best_state), .tb_done_i(tb_done), .frame_done_o(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dut_cur(input int i);
    case (i)
      0: return pm_cur0;
      1: return pm_cur1;
      2: return pm_cur2;
      default: return pm_cur3;
    endcase
  endfunction

  task automatic model_rearm();
    m_cur[0] = 0;
    for (int i = 1; i < 4; i++) m_cur[i] = BIAS;
    m_step = 0;
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 4; i++) chk_eq($sformatf("%s_cur%0d", tag, i), dut_cur(i), m_cur[i]);
    chk_eq({tag, "_step"}, step_cnt, m_step);
  endtask

  task automatic check_reset_vals(input string tag);
    chk_eq({tag, "_rdy"}, code_ready, 1);
    chk_eq({tag, "_st"}, pm_st, 0);
    chk_eq({tag, "_code"}, pm_code, 0);
    chk_eq({tag, "_tbs"}, tb_start, 0);
    chk_eq({tag, "_fd"}, frame_done, 0);
    chk_eq({tag, "_best"}, best_state, 0);
    model_rearm();
    check_model(tag);
  endtask

  task automatic do_step(input logic [1:0] code, input int lat, input logic [3:0][7:0] nv,
                         input bit stray_tb);
    int mn;
    int w;
    chk_eq("rdy_idle", code_ready, 1);
    code_valid = 1'b1;
    code_in = code;
    @(posedge clk); #1;
    for (int i = 0; i < lat; i++) begin
      chk_eq("pm_st_run", pm_st, 1);
      chk_eq("pm_code_hold", pm_code, code);
      chk_eq("rdy_run", code_ready, 0);
      check_model("run_hold");
      code_in = 2'($urandom);
      tb_done = stray_tb && (i == 0);
      if (i == lat - 1) begin
        pm_done = 1'b1;
        {pm_new3, pm_new2, pm_new1, pm_new0} = nv;
      end
      @(posedge clk); #1;
      tb_done = 1'b0;
    end
    pm_done = 1'b0;
    code_valid = 1'b0;
    chk_eq("pm_st_off", pm_st, 0);
    mn = 255;
    for (int i = 0; i < 4; i++) if (int'(nv[i]) < mn) mn = int'(nv[i]);
    for (int i = 0; i < 4; i++) m_cur[i] = int'(nv[i]) - mn;
    m_step++;
    if (m_step < FL) begin
      chk_eq("rdy_next", code_ready, 1);
      chk_eq("tbs_quiet", tb_start, 0);
      check_model("step");
    end else begin
      m_best = 3;
      for (int i = 3; i >= 0; i--) if (int'(nv[i]) == mn) m_best = i;
      chk_eq("tb_start", tb_start, 1);
      chk_eq("frame_done", frame_done, 1);
      chk_eq("best_state", best_state, m_best);
      chk_eq("rdy_tb", code_ready, 0);
      check_model("tb");
      w = $urandom_range(0, 3);
      for (int j = 0; j <= w; j++) begin
        if (j > 0) begin
          chk_eq("tbs_pulse", tb_start, 0);
          chk_eq("fd_pulse", frame_done, 0);
          chk_eq("rdy_tbwait", code_ready, 0);
          chk_eq("st_tbwait", pm_st, 0);
        end
        if (j == w) tb_done = 1'b1;
        @(posedge clk); #1;
        tb_done = 1'b0;
      end
      chk_eq("rdy_rearm", code_ready, 0);
      chk_eq("tbs_rearm", tb_start, 0);
      chk_eq("best_hold", best_state, m_best);
      @(posedge clk); #1;
      model_rearm();
      chk_eq("rdy_after", code_ready, 1);
      check_model("rearm");
    end
  endtask

  initial begin
    logic [3:0][7:0] nv;
    total = 0;
    bad = 0;
    m_best = 0;
    rst_n = 1'b0;
    code_valid = 1'b0;
    code_in = 2'd0;
    pm_done = 1'b0;
    tb_done = 1'b0;
    {pm_new3, pm_new2, pm_new1, pm_new0} = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single step with the documented stub values
    do_step(2'b11, 3, {8'd2, 8'd7, 8'd2, 8'd5}, 1'b0);

    // short mid-cycle reset
    #1 rst_n = 1'b0;
    #2 check_reset_vals("async_rst");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_eq("rel_rdy", code_ready, 1);
    check_model("rel");

    // stray pm_done while idle
    repeat (3) begin
      pm_done = 1'b1;
      {pm_new3, pm_new2, pm_new1, pm_new0} = 32'($urandom);
      @(posedge clk); #1;
      chk_eq("stray_rdy", code_ready, 1);
      chk_eq("stray_st", pm_st, 0);
      check_model("stray");
    end
    pm_done = 1'b0;

    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < FL; s++) begin
        nv = 32'($urandom);
        if (f == 0 && s == FL - 1) nv = {8'd12, 8'd4, 8'd4, 8'd9};
        do_step(2'($urandom), $urandom_range(1, 4), nv, 1'($urandom));
      end
    end

    // reset while the path-metric unit is busy, then a late pm_done
    do_step(2'b01, 2, {8'd40, 8'd30, 8'd20, 8'd10}, 1'b0);
    code_valid = 1'b1;
    code_in = 2'b10;
    @(posedge clk); #1;
    code_valid = 1'b0;
    chk_eq("mid_run_st", pm_st, 1);
    #1 rst_n = 1'b0;
    #2 check_reset_vals("run_rst");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    pm_done = 1'b1;
    {pm_new3, pm_new2, pm_new1, pm_new0} = {8'd9, 8'd8, 8'd7, 8'd6};
    @(posedge clk); #1;
    pm_done = 1'b0;
    chk_eq("late_rdy", code_ready, 1);
    chk_eq("late_st", pm_st, 0);
    check_model("late");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/path_metric_sequencer.md
PATH_METRIC_SEQUENCER -- requirements
Module: path_metric_sequencer

Interface
REQ-001 Parameter FRAME_LEN, default 16: trellis steps per frame, range 2..255.
REQ-002 Parameter INIT_BIAS, default 8'd63: start-of-frame metric for states 1..3.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 code_valid  in  1  received code symbol available.
REQ-006 code_ready  out  1  sequencer accepts a symbol this cycle.
REQ-007 code_in  in  2  received rate-1/2 symbol.
REQ-008 pm_st  out  1  start/hold request to the path-metric unit.
REQ-009 pm_code  out  2  symbol presented to the path-metric unit.
REQ-010 pm_cur0..pm_cur3  out  8 each  current state metrics driven to the path-metric unit.
REQ-011 pm_new0..pm_new3  in  8 each  updated metrics returned by the path-metric unit.
REQ-012 pm_done  in  1  path-metric unit result valid.
REQ-013 step_cnt  out  8  trellis steps completed in the current frame.
REQ-014 tb_start  out  1  one-cycle pulse starting traceback.
REQ-015 best_state  out  2  state with the minimum final metric; valid from tb_start onward.
REQ-016 tb_done  in  1  traceback finished pulse.
REQ-017 frame_done  out  1  one-cycle pulse, frame closed.

Function
REQ-018 FSM states: IDLE, RUN, TB, REARM; no other reachable state.
REQ-019 IDLE: code_ready=1; code_valid=1 captures code_in into pm_code; next state RUN.
REQ-020 code_ready is 0 in RUN, TB and REARM; code_valid is ignored there.
REQ-021 RUN: pm_st=1 every cycle until pm_done sampled 1; pm_code and pm_cur0..3 are held stable throughout RUN.
REQ-022 pm_done sampled outside RUN is ignored.
REQ-023 On pm_done in RUN, m = min(pm_new0..3), unsigned 8-bit.
REQ-024 In that same cycle, pm_cur_i <= pm_new_i - m for each i; the result never underflows.
REQ-025 In that same cycle, step_cnt increments.
REQ-026 Next state after pm_done: IDLE if the new step_cnt < FRAME_LEN, else TB.
REQ-027 Minimum latency: symbol accepted at edge N -> pm_st high from N+1; a result arriving at edge N+k -> code_ready high at N+k+1.
REQ-028 Entry to TB: tb_start=1 and frame_done=1 for exactly the first TB cycle.
REQ-029 Same cycle: best_state = lowest index i with pm_cur_i==0; ties resolve to the lowest index.
REQ-030 TB waits for tb_done; tb_done arriving in the tb_start cycle is honoured.
REQ-031 tb_done in TB -> REARM, which lasts one cycle and loads pm_cur0=0, pm_cur1..3=INIT_BIAS, step_cnt=0; next state IDLE.
REQ-032 best_state holds its value until the next tb_start.
REQ-033 pm_st is 0 in IDLE, TB and REARM.
REQ-034 tb_start and frame_done are 0 except in the REQ-028 cycle.

Reset
REQ-035 rst=0 forces the state to IDLE immediately, without waiting for a clock edge.
REQ-036 rst=0 outputs: code_ready=1, pm_st=0, pm_code=0, pm_cur0=0, pm_cur1..3=INIT_BIAS, step_cnt=0, tb_start=0, frame_done=0, best_state=0.
REQ-037 Reset during RUN or TB abandons the frame; a pm_done or tb_done arriving after release is ignored unless the FSM is in RUN or TB respectively.
REQ-038 The first accepted symbol after rst rises starts a fresh frame at step 0.

Verification
REQ-039 Reset: rst low 4 ns mid-cycle -> outputs match REQ-036 before the next edge; after release code_ready=1, pm_cur=0/63/63/63.
REQ-040 Single step: code_in=2'b11 with code_valid; stub returns pm_new=5/2/7/2 after 3 cycles -> pm_st high exactly 3 cycles, pm_cur=3/0/5/0, step_cnt=1, code_ready=1 the next cycle.
REQ-041 Backpressure: code_valid held high during RUN with a changing code_in -> pm_code unchanged until RUN exits; no symbol is lost or duplicated.
REQ-042 Frame end: FRAME_LEN=4, stub final pm_new=9/4/4/12 -> tb_start and frame_done are 1-cycle pulses, best_state=1, code_ready=0 until 1 cycle after tb_done, then pm_cur=0/63/63/63 and step_cnt=0.
REQ-043 Stray handshakes: pm_done pulsed in IDLE and tb_done pulsed in RUN -> no state, metric or counter change.
REQ-044 Reset mid-RUN: rst low while pm_st=1, stub asserts pm_done after release -> ignored, step_cnt=0, FSM in IDLE.
